// File: rtl/conv_window_gen_pkg.sv
// Shared parameters, types and helpers for the 3x3 convolution window generator.
//   INT_BITS : width of one pixel value
//   CH       : channels processed in parallel
//   DIM_BITS : width of the image row/column counters
package conv_window_gen_pkg;

    localparam int unsigned INT_BITS = 13;
    localparam int unsigned CH       = 9;
    localparam int unsigned DIM_BITS = 10;

    localparam int unsigned COL_W = 3 * INT_BITS;
    localparam int unsigned WIN_W = 9 * INT_BITS;

    // Slice index of each image row inside one input column
    localparam int unsigned COL_TOP = 2;
    localparam int unsigned COL_MID = 1;
    localparam int unsigned COL_BOT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef logic [CH-1:0][COL_W-1:0] col_bus_t;
    typedef logic [CH-1:0][WIN_W-1:0] win_bus_t;

    // Position tag that travels with every emitted window
    typedef struct packed {
        logic [DIM_BITS-1:0] row;
        logic [DIM_BITS-1:0] col;
        logic                done;
    } win_tag_t;

    function automatic logic [INT_BITS-1:0] col_slice(input logic [COL_W-1:0] c,
                                                      input int unsigned      idx);
        return c[idx*INT_BITS +: INT_BITS];
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Column-in / window-out bus of the window generator.
//   slave  : the generator (takes start/geometry/columns, drives windows)
//   master : the upstream/downstream side (testbench or line buffer + MAC array)
interface conv_window_gen_if;
    import conv_window_gen_pkg::*;

    logic                start;
    logic [DIM_BITS-1:0] img_w;
    logic [DIM_BITS-1:0] img_h;
    logic                valid_in;
    col_bus_t            col_in;
    win_bus_t            win_out;
    logic                win_valid;
    logic [DIM_BITS-1:0] win_row;
    logic [DIM_BITS-1:0] win_col;
    logic                frame_done;
    logic                busy;

    modport slave (
        input  start, img_w, img_h, valid_in, col_in,
        output win_out, win_valid, win_row, win_col, frame_done, busy
    );

    modport master (
        output start, img_w, img_h, valid_in, col_in,
        input  win_out, win_valid, win_row, win_col, frame_done, busy
    );

endinterface

// File: rtl/conv_window_gen_win_shift3x3.sv
// One channel's L/M/R column registers and its registered, vertically masked 3x3 window.
//   clk, reset    : clock, async active-high reset
//   i_clear       : zero L/M/R (left padding for a new row)
//   i_load0       : L,M <= 0, R <= i_col (column 0 of a new row)
//   i_shift       : L <= M, M <= R, R <= i_col
//   i_emit        : register a new window
//   i_emit_flush  : window right column is padding instead of i_col
//   i_mask_top/bot: force top/bottom window row to zero
//   o_win         : row-major window, MSB slice = top-left
module conv_window_gen_win_shift3x3
    import conv_window_gen_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_load0,
    input  logic             i_shift,
    input  logic             i_emit,
    input  logic             i_emit_flush,
    input  logic             i_mask_top,
    input  logic             i_mask_bot,
    input  logic [COL_W-1:0] i_col,
    output logic [WIN_W-1:0] o_win
);

    logic [COL_W-1:0] r_l, r_m, r_r;
    logic [COL_W-1:0] w_l_nxt, w_m_nxt, w_r_nxt;
    logic [COL_W-1:0] w_right;
    logic [WIN_W-1:0] w_win;
    logic [WIN_W-1:0] r_win;

    // Next column register contents
    always_comb begin
        w_l_nxt = r_l;
        w_m_nxt = r_m;
        w_r_nxt = r_r;
        if (i_clear) begin
            w_l_nxt = '0;
            w_m_nxt = '0;
            w_r_nxt = '0;
        end else if (i_load0) begin
            w_l_nxt = '0;
            w_m_nxt = '0;
            w_r_nxt = i_col;
        end else if (i_shift) begin
            w_l_nxt = r_m;
            w_m_nxt = r_r;
            w_r_nxt = i_col;
        end
    end

    // Window after the shift is {M, R, col}; a flush uses {M, R, 0}
    always_comb begin
        w_right = i_emit_flush ? '0 : i_col;
        w_win   = {col_slice(r_m, COL_TOP), col_slice(r_r, COL_TOP), col_slice(w_right, COL_TOP),
                   col_slice(r_m, COL_MID), col_slice(r_r, COL_MID), col_slice(w_right, COL_MID),
                   col_slice(r_m, COL_BOT), col_slice(r_r, COL_BOT), col_slice(w_right, COL_BOT)};
        if (i_mask_top) w_win[WIN_W-1 -: 3*INT_BITS] = '0;
        if (i_mask_bot) w_win[3*INT_BITS-1:0]        = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_l   <= '0;
            r_m   <= '0;
            r_r   <= '0;
            r_win <= '0;
        end else begin
            r_l <= w_l_nxt;
            r_m <= w_m_nxt;
            r_r <= w_r_nxt;
            if (i_emit) r_win <= w_win;
        end
    end

    assign o_win = r_win;

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 window generator with 1-pixel zero padding ("same" convolution).
// Turns 3-row pixel columns into one tagged window per output pixel.
//   clk, reset : clock, async active-high reset (aborts any frame)
//   io_bus     : start/img_w/img_h/valid_in/col_in in;
//                win_out/win_valid/win_row/win_col/frame_done/busy out
module conv_window_gen
    import conv_window_gen_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    conv_window_gen_if.slave io_bus
);

    state_t              r_state, w_state_nxt;
    logic [DIM_BITS-1:0] r_w, r_h, r_col_cnt, r_row_cnt;
    logic [DIM_BITS-1:0] w_w_nxt, w_h_nxt, w_col_nxt, w_row_nxt;
    logic                r_win_valid, w_win_valid_nxt;
    logic                r_busy, w_busy_nxt;
    win_tag_t            r_tag, w_tag_nxt;
    logic                w_clear, w_load0, w_shift, w_emit, w_emit_flush;
    logic                w_last_row, w_mask_top;

    assign w_last_row = (r_row_cnt == r_h - DIM_BITS'(1));
    assign w_mask_top = (r_row_cnt == '0);

    // Next-state, counters and channel controls; start overrides everything
    always_comb begin
        w_state_nxt     = r_state;
        w_w_nxt         = r_w;
        w_h_nxt         = r_h;
        w_col_nxt       = r_col_cnt;
        w_row_nxt       = r_row_cnt;
        w_win_valid_nxt = 1'b0;
        w_tag_nxt       = r_tag;
        w_tag_nxt.done  = 1'b0;
        w_clear         = 1'b0;
        w_load0         = 1'b0;
        w_shift         = 1'b0;
        w_emit          = 1'b0;
        w_emit_flush    = 1'b0;

        if (io_bus.start) begin
            w_w_nxt   = io_bus.img_w;
            w_h_nxt   = io_bus.img_h;
            w_row_nxt = '0;
            if (io_bus.valid_in) begin
                w_load0     = 1'b1;
                w_col_nxt   = DIM_BITS'(1);
                w_state_nxt = (io_bus.img_w == DIM_BITS'(1)) ? FLUSH : RUN;
            end else begin
                w_clear     = 1'b1;
                w_col_nxt   = '0;
                w_state_nxt = RUN;
            end
        end else begin
            unique case (r_state)
                IDLE: ;
                RUN: begin
                    if (io_bus.valid_in) begin
                        w_shift   = 1'b1;
                        w_col_nxt = r_col_cnt + DIM_BITS'(1);
                        if (r_col_cnt != '0) begin
                            w_emit          = 1'b1;
                            w_win_valid_nxt = 1'b1;
                            w_tag_nxt.row   = r_row_cnt;
                            w_tag_nxt.col   = r_col_cnt - DIM_BITS'(1);
                        end
                        if (r_col_cnt == r_w - DIM_BITS'(1)) w_state_nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    w_emit          = 1'b1;
                    w_emit_flush    = 1'b1;
                    w_win_valid_nxt = 1'b1;
                    w_tag_nxt.row   = r_row_cnt;
                    w_tag_nxt.col   = r_w - DIM_BITS'(1);
                    w_tag_nxt.done  = w_last_row;
                    if (w_last_row) begin
                        w_clear     = 1'b1;
                        w_col_nxt   = '0;
                        w_row_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_row_nxt = r_row_cnt + DIM_BITS'(1);
                        if (io_bus.valid_in) begin
                            w_load0     = 1'b1;
                            w_col_nxt   = DIM_BITS'(1);
                            // a 1-pixel-wide row is complete as soon as col 0 arrives
                            w_state_nxt = (r_w == DIM_BITS'(1)) ? FLUSH : RUN;
                        end else begin
                            w_clear     = 1'b1;
                            w_col_nxt   = '0;
                            w_state_nxt = RUN;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_w         <= '0;
            r_h         <= '0;
            r_col_cnt   <= '0;
            r_row_cnt   <= '0;
            r_win_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_tag       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_w         <= w_w_nxt;
            r_h         <= w_h_nxt;
            r_col_cnt   <= w_col_nxt;
            r_row_cnt   <= w_row_nxt;
            r_win_valid <= w_win_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_tag       <= w_tag_nxt;
        end
    end

    // Per-channel column registers sharing one controller
    for (genvar g = 0; g < CH; g++) begin : g_ch
        conv_window_gen_win_shift3x3 u_shift (
            .clk          (clk),
            .reset        (reset),
            .i_clear      (w_clear),
            .i_load0      (w_load0),
            .i_shift      (w_shift),
            .i_emit       (w_emit),
            .i_emit_flush (w_emit_flush),
            .i_mask_top   (w_mask_top),
            .i_mask_bot   (w_last_row),
            .i_col        (io_bus.col_in[g]),
            .o_win        (io_bus.win_out[g])
        );
    end

    assign io_bus.win_valid  = r_win_valid;
    assign io_bus.win_row    = r_tag.row;
    assign io_bus.win_col    = r_tag.col;
    assign io_bus.frame_done = r_tag.done;
    assign io_bus.busy       = r_busy;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed + random bench for conv_window_gen with a raster-order window scoreboard.
module tb_conv_window_gen;
    import conv_window_gen_pkg::*;

    typedef struct packed {
        win_bus_t            win;
        logic [DIM_BITS-1:0] row;
        logic [DIM_BITS-1:0] col;
        logic                done;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    conv_window_gen_if bus();

    conv_window_gen dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    exp_t             sb[$];
    exp_t             m_e;
    col_bus_t         rc [0:1023];
    logic [WIN_W-1:0] obs_ch0 [0:15];
    int n_cmp = 0, n_fail = 0;
    int n_win = 0, n_done = 0, cyc = 0, first_cyc = 0, last_cyc = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference window from the stored raster row, with zero padding on all edges
    function automatic win_bus_t build_win(input int r, input int k, input int w, input int h);
        win_bus_t         wv;
        logic [COL_W-1:0] c;
        logic [INT_BITS-1:0] px;
        wv = '0;
        for (int ch = 0; ch < CH; ch++) begin
            for (int j = 0; j < 3; j++) begin
                int cc;
                cc = k - 1 + j;
                c  = (cc < 0 || cc >= w) ? '0 : rc[cc][ch];
                for (int i = 0; i < 3; i++) begin
                    px = c[(2-i)*INT_BITS +: INT_BITS];
                    if ((i == 0 && r == 0) || (i == 2 && r == h - 1)) px = '0;
                    wv[ch][(8-(i*3+j))*INT_BITS +: INT_BITS] = px;
                end
            end
        end
        return wv;
    endfunction

    function automatic col_bus_t rand_col();
        col_bus_t c;
        for (int ch = 0; ch < CH; ch++)
            for (int s = 0; s < 3; s++)
                c[ch][s*INT_BITS +: INT_BITS] = INT_BITS'($urandom);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_start(input int w, input int h);
        bus.start = 1'b1;
        bus.img_w = DIM_BITS'(w);
        bus.img_h = DIM_BITS'(h);
        tick();
        bus.start = 1'b0;
    endtask

    // Drive one column; expected windows it completes go to the scoreboard first
    task automatic send(input int r, input int k, input int w, input int h,
                        input col_bus_t c, input bit with_start);
        exp_t e;
        rc[k] = c;
        if (k >= 1) begin
            e = '{build_win(r, k-1, w, h), DIM_BITS'(r), DIM_BITS'(k-1), 1'b0};
            sb.push_back(e);
        end
        if (k == w - 1) begin
            e = '{build_win(r, k, w, h), DIM_BITS'(r), DIM_BITS'(k), 1'(r == h - 1)};
            sb.push_back(e);
        end
        bus.col_in   = c;
        bus.valid_in = 1'b1;
        if (with_start) begin
            bus.start = 1'b1;
            bus.img_w = DIM_BITS'(w);
            bus.img_h = DIM_BITS'(h);
        end
        tick();
        bus.valid_in = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input int max_gap);
        do_start(w, h);
        for (int r = 0; r < h; r++)
            for (int k = 0; k < w; k++) begin
                if (max_gap > 0) idle($urandom_range(max_gap, 0));
                send(r, k, w, h, rand_col(), 1'b0);
            end
        idle(3);
    endtask

    task automatic clear_counts();
        n_win  = 0;
        n_done = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 128'(bus.win_valid), 128'(0));
        check({tag, "_busy"},  128'(bus.busy),      128'(0));
        check({tag, "_done"},  128'(bus.frame_done), 128'(0));
        check({tag, "_row"},   128'(bus.win_row),   128'(0));
        check({tag, "_col"},   128'(bus.win_col),   128'(0));
        for (int ch = 0; ch < CH; ch++)
            check($sformatf("%s_win%0d", tag, ch), 128'(bus.win_out[ch]), 128'(0));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        cyc++;
        if (!reset && bus.win_valid) begin
            if (n_win == 0) first_cyc = cyc;
            last_cyc = cyc;
            n_win++;
            if (bus.frame_done) n_done++;
            if (bus.win_col < 16) obs_ch0[bus.win_col[3:0]] = bus.win_out[0];
            check("sb_has_entry", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                m_e = sb.pop_front();
                check("win_row",    128'(bus.win_row),    128'(m_e.row));
                check("win_col",    128'(bus.win_col),    128'(m_e.col));
                check("frame_done", 128'(bus.frame_done), 128'(m_e.done));
                for (int ch = 0; ch < CH; ch++)
                    check($sformatf("win_ch%0d", ch), 128'(bus.win_out[ch]), 128'(m_e.win[ch]));
            end
        end
    end

    initial begin
        bus.start    = 1'b0;
        bus.img_w    = '0;
        bus.img_h    = '0;
        bus.valid_in = 1'b0;
        bus.col_in   = '0;
        #1;
        check_outputs_zero("por");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: reset mid-frame at col 3 of row 1
        clear_counts();
        do_start(5, 3);
        for (int k = 0; k < 5; k++) send(0, k, 5, 3, rand_col(), 1'b0);
        for (int k = 0; k < 3; k++) send(1, k, 5, 3, rand_col(), 1'b0);
        idle(1);
        check("t1_sb_drained", 128'(sb.size()), 128'(0));
        check("t1_nwin", 128'(n_win), 128'(7));
        bus.col_in   = rand_col();
        bus.valid_in = 1'b1;
        reset        = 1'b1;
        #1;
        check_outputs_zero("t1_rst");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.col_in   = rand_col();
            bus.valid_in = 1'b1;
            tick();
            check("t1_busy_after", 128'(bus.busy),      128'(0));
            check("t1_nowin_after", 128'(bus.win_valid), 128'(0));
        end
        idle(2);

        // 2: W=4 H=1 directed pattern on ch0
        clear_counts();
        do_start(4, 1);
        check("t2_busy", 128'(bus.busy), 128'(1));
        for (int k = 0; k < 4; k++) begin
            col_bus_t c;
            c    = rand_col();
            c[0] = {INT_BITS'(10*k+1), INT_BITS'(10*k+2), INT_BITS'(10*k+3)};
            send(0, k, 4, 1, c, 1'b0);
        end
        idle(3);
        check("t2_nwin",  128'(n_win),  128'(4));
        check("t2_ndone", 128'(n_done), 128'(1));
        check("t2_win0_ch0", 128'(obs_ch0[0]),
              128'({INT_BITS'(0), INT_BITS'(0), INT_BITS'(0),
                    INT_BITS'(0), INT_BITS'(2), INT_BITS'(12),
                    INT_BITS'(0), INT_BITS'(0), INT_BITS'(0)}));
        check("t2_win3_ch0", 128'(obs_ch0[3]),
              128'({INT_BITS'(0), INT_BITS'(0), INT_BITS'(0),
                    INT_BITS'(22), INT_BITS'(32), INT_BITS'(0),
                    INT_BITS'(0), INT_BITS'(0), INT_BITS'(0)}));
        check("t2_busy_end", 128'(bus.busy), 128'(0));

        // 3: W=3 H=3, new row's col 0 arrives in every FLUSH cycle
        clear_counts();
        run_frame(3, 3, 0);
        check("t3_nwin",  128'(n_win),  128'(9));
        check("t3_ndone", 128'(n_done), 128'(1));
        check("t3_no_gaps", 128'(last_cyc - first_cyc), 128'(8));

        // 4: W=1 H=2
        clear_counts();
        run_frame(1, 2, 0);
        check("t4_nwin",  128'(n_win),  128'(2));
        check("t4_ndone", 128'(n_done), 128'(1));

        // 5: restart with start + valid_in at col 2 of a W=5 frame
        clear_counts();
        do_start(5, 2);
        send(0, 0, 5, 2, rand_col(), 1'b0);
        send(0, 1, 5, 2, rand_col(), 1'b0);
        send(0, 0, 5, 2, rand_col(), 1'b1);
        check("t5_no_win_on_restart", 128'(bus.win_valid), 128'(0));
        check("t5_busy", 128'(bus.busy), 128'(1));
        for (int k = 1; k < 5; k++) send(0, k, 5, 2, rand_col(), 1'b0);
        for (int k = 0; k < 5; k++) send(1, k, 5, 2, rand_col(), 1'b0);
        idle(3);
        check("t5_nwin",  128'(n_win),  128'(11));
        check("t5_ndone", 128'(n_done), 128'(1));

        // 6: random gaps, W=7 H=5, all channels
        clear_counts();
        run_frame(7, 5, 3);
        check("t6_nwin",  128'(n_win),  128'(35));
        check("t6_ndone", 128'(n_done), 128'(1));
        check("t6_sb_empty", 128'(sb.size()), 128'(0));
        check("t6_busy_end", 128'(bus.busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
